// File: rtl/grid_game_writer_pkg.sv
// Shared grid geometry, cell colours and sequencer state encoding for the
// grid game writer.
package grid_game_writer_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;
  localparam int PAD_W  = 3;
  localparam int XW     = $clog2(GRID_W);
  localparam int YW     = $clog2(GRID_H);
  localparam int CELLS  = GRID_W * GRID_H;

  localparam logic [2:0] COL_BG     = 3'b000;
  localparam logic [2:0] COL_PADDLE = 3'b001;
  localparam logic [2:0] COL_BALL   = 3'b100;

  localparam logic [XW-1:0] PAD_X0  = XW'((GRID_W - PAD_W) / 2);
  localparam logic [XW-1:0] BALL_X0 = XW'(GRID_W / 2);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_DRAW,
    ST_WAIT,
    ST_ERASE,
    ST_UPDATE
  } state_e;

endpackage

// File: rtl/grid_game_writer_btn_edge_sync.sv
// Two-flop synchronizer for a raw button followed by a one-cycle rising-edge pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  // [0],[1] synchronizer stages, [2] previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], btn_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/grid_game_writer.sv
// Paddle/ball game on a cell grid; each step only the changed cells are
// streamed into the framebuffer RAM write port, one cell per cycle.
module grid_game_writer
  import grid_game_writer_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 3,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_r,
  input  logic          btn_l,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output state_e        dbg_state_o
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] tick_cnt_q;
  logic          tick;
  logic          rise_r, rise_l;
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [XW-1:0] pad_q, bx_q, pad_nx, x_nx;
  logic [YW-1:0] by_q, y_nx;
  logic          dx_pos_q, dy_pos_q, dx_nx, dy_nx, miss;
  logic          pend_r_q, pend_l_q, consume;
  logic          is_ball;
  logic [AW-1:0] seq_addr;

  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(x) + AW'(y) * AW'(GRID_W);
  endfunction

  btn_edge_sync u_sync_r (.clk(clk), .rst(rst), .btn_i(btn_r), .rise_o(rise_r));
  btn_edge_sync u_sync_l (.clk(clk), .rst(rst), .btn_i(btn_l), .rise_o(rise_l));

  assign tick = (tick_cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt_q <= '0;
    else             tick_cnt_q <= tick_cnt_q + CW'(1);
  end

  // ERASE/DRAW slots 0..PAD_W-1 are paddle cells, the last slot is the ball.
  assign is_ball = (idx_q == AW'(PAD_W));
  always_comb begin
    seq_addr = cell_addr(bx_q, by_q);
    if (!is_ball) seq_addr = cell_addr(pad_q + XW'(idx_q), YW'(GRID_H - 1));
  end

  // px_wr is a valid with no back-pressure: addr/data qualify the same cycle
  // and the RAM accepts every strobe.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    consume = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_d   = 1'b1;
        addr_d = idx_q;
        data_d = DW'(COL_BG);
        if (idx_q == AW'(CELLS - 1)) begin
          idx_d   = '0;
          state_d = ST_DRAW;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_DRAW, ST_ERASE: begin
        wr_d   = 1'b1;
        addr_d = seq_addr;
        if (state_q == ST_ERASE) data_d = DW'(COL_BG);
        else                     data_d = is_ball ? DW'(COL_BALL) : DW'(COL_PADDLE);
        if (is_ball) begin
          idx_d   = '0;
          state_d = (state_q == ST_ERASE) ? ST_UPDATE : ST_WAIT;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_WAIT: begin
        if (tick) state_d = ST_ERASE;
      end
      ST_UPDATE: begin
        consume = 1'b1;
        idx_d   = '0;
        state_d = miss ? ST_CLEAR : ST_DRAW;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next game state, applied only in the UPDATE cycle.
  always_comb begin
    pad_nx = pad_q;
    if (pend_r_q && !pend_l_q && (int'(pad_q) + PAD_W < GRID_W)) pad_nx = pad_q + XW'(1);
    else if (pend_l_q && !pend_r_q && pad_q != '0)              pad_nx = pad_q - XW'(1);

    dx_nx = dx_pos_q;
    if ((bx_q == XW'(GRID_W - 1) && dx_pos_q) || (bx_q == '0 && !dx_pos_q)) dx_nx = !dx_pos_q;
    x_nx = dx_nx ? bx_q + XW'(1) : bx_q - XW'(1);

    dy_nx = dy_pos_q;
    miss  = 1'b0;
    if (by_q == '0 && !dy_pos_q) dy_nx = 1'b1;
    if (by_q == YW'(GRID_H - 2) && dy_nx) begin
      if (x_nx >= pad_nx && x_nx <= pad_nx + XW'(PAD_W - 1)) dy_nx = 1'b0;
      else                                                   miss  = 1'b1;
    end
    y_nx = dy_nx ? by_q + YW'(1) : by_q - YW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_q    <= PAD_X0;
      bx_q     <= BALL_X0;
      by_q     <= '0;
      dx_pos_q <= 1'b1;
      dy_pos_q <= 1'b1;
      pend_r_q <= 1'b0;
      pend_l_q <= 1'b0;
    end else begin
      // An edge arriving in the UPDATE cycle itself survives for the next step.
      pend_r_q <= (pend_r_q & ~consume) | rise_r;
      pend_l_q <= (pend_l_q & ~consume) | rise_l;
      if (consume) begin
        if (miss) begin
          pad_q    <= PAD_X0;
          bx_q     <= BALL_X0;
          by_q     <= '0;
          dx_pos_q <= 1'b1;
          dy_pos_q <= 1'b1;
        end else begin
          pad_q    <= pad_nx;
          bx_q     <= x_nx;
          by_q     <= y_nx;
          dx_pos_q <= dx_nx;
          dy_pos_q <= dy_nx;
        end
      end
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_grid_game_writer.sv
// Directed bench for grid_game_writer: mid-clear reset, full clear/draw,
// a 30-step scripted game with button actions, and a paddle miss.
module tb_grid_game_writer;
  import grid_game_writer_pkg::*;

  localparam int AW = 8;
  localparam int DW = 3;
  localparam int TD = 16;
  localparam int NS = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_r = 1'b0;
  logic          btn_l = 1'b0;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  int unsigned cyc = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];
  int unsigned      obs_cyc_q[$];

  // Hand-computed game script: paddle_x, ball x, ball y after step k (k=0 is the
  // first draw), and the button action applied in WAIT after that step's draw:
  // 0 none, 1 pulse r, 2 press r, 3 release r, 4 pulse r+l, 5 pulse l.
  int pad_t[NS] = '{6, 6, 7, 8, 8, 8, 8, 8, 8, 8, 8, 9, 10, 11, 12, 13,
                    13, 13, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12};
  int bx_t[NS]  = '{8, 9, 10, 11, 12, 13, 14, 15, 14, 13, 12, 11, 10, 9, 8, 7,
                    6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 8};
  int by_t[NS]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 9, 8, 7, 6, 5,
                    4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int act_t[NS] = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1, 1, 1, 1,
                    4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  grid_game_writer #(.AW(AW), .DW(DW), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_r       (btn_r),
    .btn_l       (btn_l),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .dbg_state_o (dbg_state)
  );

  // clock/reset
  always #10 clk = ~clk;

  // write monitor, sampled 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (px_wr) begin
      obs_q.push_back({mem_px_addr, mem_px_data});
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void exp_w(input int a, input logic [DW-1:0] d);
    exp_q.push_back({AW'(a), d});
  endfunction

  function automatic void exp_clear(input int n);
    for (int i = 0; i < n; i++) exp_w(i, 3'b000);
  endfunction

  function automatic void exp_cells(input int pad, input int x, input int y, input bit draw);
    for (int i = 0; i < 3; i++) exp_w(176 + pad + i, draw ? 3'b001 : 3'b000);
    exp_w(x + 16 * y, draw ? 3'b100 : 3'b000);
  endfunction

  // scoreboard: pair every expected write with the next observed write
  task automatic drain(input string tag, input bit back_to_back);
    logic [AW+DW-1:0] e, o;
    int unsigned c, prev_c;
    int n, k;
    k = 0;
    prev_c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (obs_q.size() == 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("%s[%0d] write seen", tag, k), 64'(obs_q.size() != 0), 64'(1));
      if (obs_q.size() == 0) begin
        exp_q.delete();
        timeouts++;
        if (timeouts >= 3) begin
          summary();
          $finish;
        end
        return;
      end
      o = obs_q.pop_front();
      c = obs_cyc_q.pop_front();
      check($sformatf("%s[%0d] addr", tag, k), 64'(o[AW+DW-1:DW]), 64'(e[AW+DW-1:DW]));
      check($sformatf("%s[%0d] data", tag, k), 64'(o[DW-1:0]), 64'(e[DW-1:0]));
      if (back_to_back && k > 0) check($sformatf("%s[%0d] gap", tag, k), 64'(c - prev_c), 64'(1));
      prev_c = c;
      k++;
    end
  endtask

  task automatic pulse(input logic r, input logic l);
    @(posedge clk);
    #1;
    btn_r = r;
    btn_l = l;
    @(posedge clk);
    #1;
    btn_r = 1'b0;
    btn_l = 1'b0;
  endtask

  task automatic do_act(input int a);
    case (a)
      1: pulse(1'b1, 1'b0);
      2: btn_r = 1'b1;
      3: btn_r = 1'b0;
      4: pulse(1'b1, 1'b1);
      5: pulse(1'b0, 1'b1);
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active, expected completion within 100000 cycles");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset px_wr", 64'(px_wr), 64'(0));
    check("reset addr", 64'(mem_px_addr), 64'(0));
    check("reset data", 64'(mem_px_data), 64'(0));
    check("reset state", 64'(dbg_state), 64'(ST_CLEAR));
    rst = 1'b0;

    // reset after 100 clear writes: strobe drops, clear restarts at 0
    exp_clear(100);
    drain("clear_part", 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midclear rst px_wr", 64'(px_wr), 64'(0));
    check("midclear rst addr", 64'(mem_px_addr), 64'(0));
    check("midclear rst state", 64'(dbg_state), 64'(ST_CLEAR));
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    obs_cyc_q.delete();

    exp_clear(192);
    exp_cells(pad_t[0], bx_t[0], by_t[0], 1'b1);
    drain("init", 1'b1);
    @(negedge clk);
    check("idle after init draw", 64'(px_wr), 64'(0));
    check("wait state after init", 64'(dbg_state), 64'(ST_WAIT));
    do_act(act_t[0]);

    for (int k = 1; k < NS; k++) begin
      exp_cells(pad_t[k-1], bx_t[k-1], by_t[k-1], 1'b0);
      exp_cells(pad_t[k], bx_t[k], by_t[k], 1'b1);
      drain($sformatf("step%0d", k), 1'b0);
      do_act(act_t[k]);
    end

    // ball lands at x=9 with the paddle at 12..14: miss, full clear, reset positions
    exp_cells(pad_t[NS-1], bx_t[NS-1], by_t[NS-1], 1'b0);
    drain("miss_erase", 1'b0);
    exp_clear(192);
    exp_cells(6, 8, 0, 1'b1);
    drain("miss_clear", 1'b1);
    @(negedge clk);
    check("idle after miss redraw", 64'(px_wr), 64'(0));

    summary();
    $finish;
  end

endmodule
